// File: rtl/axi_config_pkg.sv
// Shared constants and helpers for the AXI4 burst-to-register write path.
// Burst/response encodings, FSM state type and WRAP length validation.
package axi_config_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic [1:0] resp_code(input logic dec_err, input logic slv_err);
    if (dec_err) begin
      return RESP_DECERR;
    end
    if (slv_err) begin
      return RESP_SLVERR;
    end
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for AXI4 FIXED / INCR / WRAP bursts.
// Illegal WRAP lengths fall back to INCR stepping; the error is flagged elsewhere.
module axi_burst_addr_gen
  import axi_config_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] size_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] wrap_addr;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    size_mask = step - ADDR_WIDTH'(1);
    // Aligning before the add makes every beat after an unaligned first beat size-aligned.
    incr_addr = (addr & ~size_mask) + step;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    wrap_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);

    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_len_ok(len) ? wrap_addr : incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_config_wr_burst.sv
// AXI4 write slave that turns bursts into a single-beat register write stream.
// Optional address window decode enabled by defining AXI_CONFIG_WR_RANGE_CHECK_EN.
module axi_config_wr_burst
  import axi_config_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    ID_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           ADDR_SPAN  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic [3:0]            s_axi_awregion,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,

  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,

  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,

  output logic                  wr,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb
);

  localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_WIDTH));

  state_t                state_reg, state_next;

  logic                  awready_reg;
  logic [ID_WIDTH-1:0]   id_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]            len_reg;
  logic [2:0]            size_reg;
  logic [1:0]            burst_reg;
  logic [7:0]            beat_cnt_reg;
  logic                  size_err_reg;
  logic                  slv_err_reg;
  logic                  dec_err_reg;

  logic                  wr_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_WIDTH-1:0] wstrb_reg;

  logic                  aw_hs, w_hs, b_hs;
  logic                  wready_int, bvalid_int;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  range_miss;
  logic                  beat_suppress;
  logic                  wlast_err;
  logic                  aw_size_err, aw_unaligned, aw_burst_err;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .addr      (addr_reg),
    .len       (len_reg),
    .size      (size_reg),
    .burst     (burst_reg),
    .next_addr (next_addr)
  );

  // Burst-level errors are decided once, from the AW beat.
  assign aw_size_err  = s_axi_awsize > SIZE_MAX;
  assign aw_unaligned = (s_axi_awaddr & ((ADDR_WIDTH'(1) << s_axi_awsize) - ADDR_WIDTH'(1))) != '0;
  assign aw_burst_err = (s_axi_awburst == BURST_RSVD) ||
                        ((s_axi_awburst == BURST_WRAP) && (!wrap_len_ok(s_axi_awlen) || aw_unaligned));

  assign last_beat     = beat_cnt_reg == len_reg;
  assign wlast_err     = s_axi_wlast != last_beat;
  assign beat_suppress = size_err_reg || range_miss;

`ifdef AXI_CONFIG_WR_RANGE_CHECK_EN
  logic [ADDR_WIDTH-1:0] window_offset;

  assign window_offset = addr_reg - BASE_ADDR;
  assign range_miss    = (addr_reg < BASE_ADDR) || (64'(window_offset) >= 64'(ADDR_SPAN));
`else
  logic unused_window;

  assign range_miss    = 1'b0;
  assign unused_window = ^{BASE_ADDR, ADDR_SPAN};
`endif

  logic unused_aw_attr;
  assign unused_aw_attr = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    b_hs       = 1'b0;
    wready_int = 1'b0;
    bvalid_int = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        aw_hs = awready_reg && s_axi_awvalid;
        if (aw_hs) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        wready_int = !wr_reg || wr_ready;
        w_hs       = wready_int && s_axi_wvalid;
        if (w_hs && last_beat) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        // The response waits until the final beat has left the output register.
        bvalid_int = !wr_reg;
        b_hs       = bvalid_int && s_axi_bready;
        if (b_hs) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awready_reg  <= 1'b0;
      id_reg       <= '0;
      addr_reg     <= '0;
      len_reg      <= '0;
      size_reg     <= '0;
      burst_reg    <= '0;
      beat_cnt_reg <= '0;
      size_err_reg <= 1'b0;
      slv_err_reg  <= 1'b0;
      dec_err_reg  <= 1'b0;
      wr_reg       <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
    end else begin
      awready_reg <= state_next == ST_IDLE;

      if (aw_hs) begin
        id_reg       <= s_axi_awid;
        addr_reg     <= s_axi_awaddr;
        len_reg      <= s_axi_awlen;
        size_reg     <= s_axi_awsize;
        burst_reg    <= s_axi_awburst;
        beat_cnt_reg <= '0;
        size_err_reg <= aw_size_err;
        slv_err_reg  <= aw_size_err || aw_burst_err;
        dec_err_reg  <= 1'b0;
      end

      if (w_hs) begin
        waddr_reg    <= addr_reg;
        wdata_reg    <= s_axi_wdata;
        wstrb_reg    <= s_axi_wstrb;
        wr_reg       <= !beat_suppress;
        addr_reg     <= next_addr;
        beat_cnt_reg <= beat_cnt_reg + 8'd1;
        if (wlast_err) begin
          slv_err_reg <= 1'b1;
        end
        if (range_miss) begin
          dec_err_reg <= 1'b1;
        end
      end else if (wr_reg && wr_ready) begin
        wr_reg <= 1'b0;
      end
    end
  end

  assign s_axi_awready = awready_reg;
  assign s_axi_wready  = wready_int;
  assign s_axi_bvalid  = bvalid_int;
  assign s_axi_bid     = id_reg;
  assign s_axi_bresp   = resp_code(dec_err_reg, slv_err_reg);

  assign wr    = wr_reg;
  assign waddr = waddr_reg;
  assign wdata = wdata_reg;
  assign wstrb = wstrb_reg;

endmodule

// File: tb/tb_axi_config_wr_burst.sv
// Directed bench for axi_config_wr_burst: burst types, stalls, error responses, reset.
// Range-window expectations follow AXI_CONFIG_WR_RANGE_CHECK_EN.
module tb_axi_config_wr_burst;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int IW = 8;
  localparam int TIMEOUT = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] awid = '0;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] s_wdata = '0;
  logic [SW-1:0] s_wstrb = '0;
  logic          s_wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic          wr;
  logic          wr_ready = 1'b1;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;

  always #5 clk = ~clk;

  axi_config_wr_burst #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .STRB_WIDTH (SW),
    .ID_WIDTH   (IW),
    .BASE_ADDR  (32'h0),
    .ADDR_SPAN  (32'h1000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axi_awid     (awid),
    .s_axi_awaddr   (awaddr),
    .s_axi_awlen    (awlen),
    .s_axi_awsize   (awsize),
    .s_axi_awburst  (awburst),
    .s_axi_awlock   (1'b0),
    .s_axi_awcache  (4'h0),
    .s_axi_awprot   (3'h0),
    .s_axi_awqos    (4'h0),
    .s_axi_awregion (4'h0),
    .s_axi_awvalid  (awvalid),
    .s_axi_awready  (awready),
    .s_axi_wdata    (s_wdata),
    .s_axi_wstrb    (s_wstrb),
    .s_axi_wlast    (s_wlast),
    .s_axi_wvalid   (wvalid),
    .s_axi_wready   (wready),
    .s_axi_bid      (bid),
    .s_axi_bresp    (bresp),
    .s_axi_bvalid   (bvalid),
    .s_axi_bready   (bready),
    .wr             (wr),
    .wr_ready       (wr_ready),
    .waddr          (waddr),
    .wdata          (wdata),
    .wstrb          (wstrb)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sink side: every accepted write is logged; stalled writes must hold still.
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  logic [SW-1:0] got_strb[$];
  logic          toggle_mode = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      wr_ready = toggle_mode ? ~wr_ready : 1'b1;
    end
  end

  initial begin
    logic          stall_prev;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    logic [SW-1:0] hold_strb;
    stall_prev = 1'b0;
    hold_addr  = '0;
    hold_data  = '0;
    hold_strb  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_wr", 64'(wr), 64'd1);
          check("hold_waddr", 64'(waddr), 64'(hold_addr));
          check("hold_wdata", 64'(wdata), 64'(hold_data));
          check("hold_wstrb", 64'(wstrb), 64'(hold_strb));
        end
        if (wr && wr_ready) begin
          got_addr.push_back(waddr);
          got_data.push_back(wdata);
          got_strb.push_back(wstrb);
        end
        stall_prev = wr && !wr_ready;
        hold_addr  = waddr;
        hold_data  = wdata;
        hold_strb  = wstrb;
      end
    end
  end

  logic [DW-1:0] beat_data[0:3];
  logic [SW-1:0] beat_strb[0:3];
  logic [AW-1:0] exp_addr[0:3];

  task automatic set_vec(input logic [DW-1:0] d0, d1, d2, d3,
                         input logic [SW-1:0] s0, s1, s2, s3,
                         input logic [AW-1:0] a0, a1, a2, a3);
    beat_data[0] = d0; beat_data[1] = d1; beat_data[2] = d2; beat_data[3] = d3;
    beat_strb[0] = s0; beat_strb[1] = s1; beat_strb[2] = s2; beat_strb[3] = s3;
    exp_addr[0]  = a0; exp_addr[1]  = a1; exp_addr[2]  = a2; exp_addr[3]  = a3;
  endtask

  task automatic clear_log();
    got_addr.delete();
    got_data.delete();
    got_strb.delete();
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) check("aw_timeout", 64'd0, 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input int beat, input logic last);
    int n;
    s_wdata = beat_data[beat];
    s_wstrb = beat_strb[beat];
    s_wlast = last;
    wvalid  = 1'b1;
    n = 0;
    while (!wready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) check("w_timeout", 64'd0, 64'd1);
    @(negedge clk);
    wvalid  = 1'b0;
    s_wlast = 1'b0;
  endtask

  task automatic run_burst(input string name, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input int wlast_beat, input int n_wr, input logic [1:0] exp_resp);
    int n;
    clear_log();
    send_aw(id, addr, len, size, burst);
    for (int b = 0; b <= int'(len); b++) begin
      send_w(b, b == wlast_beat);
    end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) check({name, "_b_timeout"}, 64'd0, 64'd1);
    check({name, "_wr_count_at_b"}, 64'(got_addr.size()), 64'(n_wr));
    check({name, "_bid"}, 64'(bid), 64'(id));
    check({name, "_bresp"}, 64'(bresp), 64'(exp_resp));
    @(negedge clk);
    bready = 1'b0;
    check({name, "_awready_after_b"}, 64'(awready), 64'd1);
    for (int i = 0; i < n_wr; i++) begin
      if (i < got_addr.size()) begin
        check($sformatf("%s_waddr%0d", name, i), 64'(got_addr[i]), 64'(exp_addr[i]));
        check($sformatf("%s_wdata%0d", name, i), 64'(got_data[i]), 64'(beat_data[i]));
        check($sformatf("%s_wstrb%0d", name, i), 64'(got_strb[i]), 64'(beat_strb[i]));
      end
    end
    $display("burst %s id=0x%0h addr=0x%0h len=%0d writes=%0d bresp=%0d",
             name, id, addr, len, got_addr.size(), bresp);
  endtask

  initial begin
    logic seen_b;

    repeat (3) @(negedge clk);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_bresp", 64'(bresp), 64'd0);
    check("rst_bid", 64'(bid), 64'd0);
    check("rst_wr", 64'(wr), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_wstrb", 64'(wstrb), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("awready_after_rst", 64'(awready), 64'd1);

    // INCR, four aligned words with per-beat strobes
    set_vec(32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
            4'hF, 4'h3, 4'hC, 4'h1,
            32'h100, 32'h104, 32'h108, 32'h10C);
    run_burst("incr", 8'h11, 32'h100, 8'd3, 3'd2, 2'd1, 3, 4, 2'd0);

    // WRAP over a 16-byte boundary starting mid-window
    set_vec(32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003,
            4'hF, 4'hF, 4'hF, 4'hF,
            32'h18, 32'h1C, 32'h10, 32'h14);
    run_burst("wrap", 8'h22, 32'h18, 8'd3, 3'd2, 2'd2, 3, 4, 2'd0);

    // FIXED with the sink toggling ready every cycle
    toggle_mode = 1'b1;
    set_vec(32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'h0,
            4'hF, 4'h6, 4'h9, 4'h0,
            32'h40, 32'h40, 32'h40, 32'h0);
    run_burst("fixed_stall", 8'h33, 32'h40, 8'd2, 3'd2, 2'd0, 2, 3, 2'd0);
    toggle_mode = 1'b0;

    // wlast early on beat 1 and missing on beat 3
    set_vec(32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003,
            4'hF, 4'hF, 4'hF, 4'hF,
            32'h200, 32'h204, 32'h208, 32'h20C);
    run_burst("bad_wlast", 8'h44, 32'h200, 8'd3, 3'd2, 2'd1, 1, 4, 2'd2);

    // INCR crossing the top of the 4 KB window
    set_vec(32'hE000_0000, 32'hE000_0001, 32'h0, 32'h0,
            4'hF, 4'hF, 4'h0, 4'h0,
            32'hFFC, 32'h1000, 32'h0, 32'h0);
`ifdef AXI_CONFIG_WR_RANGE_CHECK_EN
    run_burst("window_edge", 8'h55, 32'hFFC, 8'd1, 3'd2, 2'd1, 1, 1, 2'd3);
`else
    run_burst("window_edge", 8'h55, 32'hFFC, 8'd1, 3'd2, 2'd1, 1, 2, 2'd0);
`endif

    // Transfer size wider than the bus: nothing written
    set_vec(32'hF000_0000, 32'h0, 32'h0, 32'h0,
            4'hF, 4'h0, 4'h0, 4'h0,
            32'h0, 32'h0, 32'h0, 32'h0);
    run_burst("oversize", 8'h66, 32'h80, 8'd0, 3'd3, 2'd1, 0, 0, 2'd2);

    // Reset asserted while beat 2 of a 4-beat burst is on the W channel
    clear_log();
    set_vec(32'h1234_0000, 32'h1234_0001, 32'h1234_0002, 32'h1234_0003,
            4'hF, 4'hF, 4'hF, 4'hF,
            32'h300, 32'h304, 32'h308, 32'h30C);
    send_aw(8'h77, 32'h300, 8'd3, 3'd2, 2'd1);
    send_w(0, 1'b0);
    send_w(1, 1'b0);
    s_wdata = beat_data[2];
    s_wstrb = beat_strb[2];
    wvalid  = 1'b1;
    rst     = 1'b1;
    #1;
    check("midrst_wr", 64'(wr), 64'd0);
    check("midrst_awready", 64'(awready), 64'd0);
    check("midrst_wready", 64'(wready), 64'd0);
    check("midrst_bvalid", 64'(bvalid), 64'd0);
    check("midrst_waddr", 64'(waddr), 64'd0);
    check("midrst_wdata", 64'(wdata), 64'd0);
    @(negedge clk);
    rst    = 1'b0;
    wvalid = 1'b0;
    seen_b = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bvalid) seen_b = 1'b1;
    end
    check("midrst_no_b", 64'(seen_b), 64'd0);
    $display("burst midrst id=0x77 addr=0x300 len=3 aborted by reset");

    set_vec(32'h5555_AAAA, 32'h0, 32'h0, 32'h0,
            4'h5, 4'h0, 4'h0, 4'h0,
            32'h400, 32'h0, 32'h0, 32'h0);
    run_burst("after_rst", 8'h88, 32'h400, 8'd0, 3'd2, 2'd1, 0, 1, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
